puf_auth_sequencer: RTL and testbench
=====================================

Name: puf_auth_sequencer

Overview:
- Initiator-side controller for the PUF wrapper; sits between system control logic and the PUF's challenge/enable/response/valid interface.
- Enroll mode: issues a fixed sequence of challenges and stores each response in an internal table.
- Authenticate mode: reissues the same sequence, accumulates the Hamming distance against the stored responses, and reports pass/fail against a threshold.

Parameters:
- N_CHAL, 16, number of challenges per run (1..256).
- CHAL_BASE, 8'h00, first challenge value.
- CHAL_STEP, 8'h01, challenge increment per step (mod 256).
- THRESH, 16, maximum total Hamming distance that still passes.
- TIMEOUT, 1000000, cycles allowed in WAIT before abort.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a run; sampled only in IDLE
- mode  in  1  0 = enroll, 1 = authenticate; latched with start
- challenge  out  8  challenge to PUF, registered
- puf_enable  out  1  PUF enable, registered
- puf_response  in  8  PUF response
- puf_valid  in  1  PUF response valid
- busy  out  1  high from start accept until return to IDLE
- done  out  1  one-cycle end-of-run pulse
- pass  out  1  auth result; held until next accepted start
- enrolled  out  1  table holds a complete, successful enrollment
- timeout_err  out  1  last run aborted on timeout; held until next start
- hd_total  out  12  accumulated Hamming distance; held until next start

Behaviour:
- Interface: one clock; reset is synchronous and active-high; ports named clk and reset.
- Reset: FSM -> IDLE; idx = 0; timer = 0; all outputs 0, including enrolled. Response table contents are not reset; enrolled gates their use.
- All outputs are registered.
- States: IDLE, WAIT, GAP, FINISH.
- IDLE:
  - start=1 and mode=1 and enrolled=0: go to FINISH with pass=0 and timeout_err=0; no PUF activity.
  - Otherwise start=1: latch mode; clear idx, hd_total, pass, timeout_err, timer; if mode=0, clear enrolled; set challenge = CHAL_BASE; set puf_enable=1; set busy=1; go to WAIT.
- WAIT:
  - Hold puf_enable=1 and challenge stable. Timer increments each cycle.
  - On puf_valid=1, capture puf_response.
    - Enroll: table[idx] = response.
    - Auth: hd_total += popcount(response ^ table[idx]).
  - After capture: puf_enable=0, timer=0, go to GAP.
  - If timer reaches TIMEOUT-1 with no valid: timeout_err=1, puf_enable=0, go to FINISH.
- GAP:
  - puf_enable stays low for exactly one cycle.
  - If idx == N_CHAL-1, go to FINISH.
  - Otherwise: idx++, challenge += CHAL_STEP (8-bit wrap), puf_enable=1, go to WAIT.
- FINISH:
  - done=1 for one cycle; busy=0 on the next edge; return to IDLE.
  - Enroll without timeout: enrolled=1.
  - Auth without timeout: pass = (hd_total <= THRESH).
  - Any timeout forces pass=0 and enrolled unchanged (i.e. 0 after an enroll attempt).
- Latency:
  - puf_enable rises on the edge that accepts start.
  - puf_enable falls on the edge that samples puf_valid.
  - done is high in the cycle starting 2 edges after the final valid-sampling edge.
- Boundaries and corner cases:
  - puf_valid outside WAIT is ignored.
  - start while busy is ignored.
  - puf_valid on the same cycle as the timeout expiry: valid wins.
  - hd_total max is 2048 (N_CHAL=256), which fits in 12 bits with no saturation needed.
  - Reset mid-run: puf_enable=0 after that edge, enrolled cleared, no done pulse.
  - N_CHAL=1: WAIT -> GAP -> FINISH.

Test Plan:
- Enroll with stub PUF (response = challenge ^ 8'hA5, valid 5 cycles after enable rises), N_CHAL=16 -> 16 enable pulses with challenges 0x00..0x0F, each followed by a 1-cycle low gap; done pulse; enrolled=1; hd_total=0.
- Auth with the same stub -> hd_total=0, pass=1, done once, timeout_err=0.
- Auth, stub flips bit0 of every response -> hd_total=16, pass=1 (THRESH=16); stub flips bits 0 and 1 -> hd_total=32, pass=0.
- Auth immediately after reset (enrolled=0) -> puf_enable never rises; done 1 cycle later; pass=0.
- Stub withholds valid on challenge 0x03, TIMEOUT=100 -> puf_enable drops after 100 WAIT cycles; timeout_err=1; pass=0; enrolled=0 if the run was an enroll.
- Assert reset during WAIT of challenge 0x07 -> busy=0, puf_enable=0, enrolled=0, no done pulse; a subsequent start restarts at challenge 0x00.

Source files
------------

// File: rtl/puf_auth_sequencer.sv
// puf_auth_sequencer: enroll/authenticate sequencer driving a PUF challenge/response interface
module puf_auth_sequencer #(
  parameter int         N_CHAL    = 16,
  parameter logic [7:0] CHAL_BASE = 8'h00,
  parameter logic [7:0] CHAL_STEP = 8'h01,
  parameter int         THRESH    = 16,
  parameter int         TIMEOUT   = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mode,
  output logic [7:0]  challenge,
  output logic        puf_enable,
  input  logic [7:0]  puf_response,
  input  logic        puf_valid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        enrolled,
  output logic        timeout_err,
  output logic [11:0] hd_total
);
  localparam int IW = N_CHAL > 1 ? $clog2(N_CHAL) : 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  typedef enum logic [1:0] {IDLE, WAIT, GAP, FINISH} state_t;
  state_t        state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [TW-1:0] timer, timer_n;
  logic          mode_q, mode_n;
  logic [7:0]    chal_n;
  logic          en_n, busy_n, done_n, pass_n, enr_n, to_n, wr;
  logic [11:0]   hd_n;
  logic [7:0]    tbl [N_CHAL];
  logic [7:0]    ref_resp;
  assign ref_resp = tbl[idx];
  // next-state and next-output computation for every registered output
  always_comb begin
    state_n = state;
    idx_n   = idx;
    timer_n = timer;
    mode_n  = mode_q;
    chal_n  = challenge;
    en_n    = puf_enable;
    busy_n  = busy;
    done_n  = 1'b0;
    pass_n  = pass;
    enr_n   = enrolled;
    to_n    = timeout_err;
    hd_n    = hd_total;
    wr      = 1'b0;
    case (state)
      IDLE: if (start) begin
        mode_n = mode;
        pass_n = 1'b0;
        to_n   = 1'b0;
        hd_n   = '0;
        busy_n = 1'b1;
        if (mode && !enrolled) state_n = FINISH;
        else begin
          idx_n   = '0;
          timer_n = '0;
          enr_n   = mode ? enrolled : 1'b0;
          chal_n  = CHAL_BASE;
          en_n    = 1'b1;
          state_n = WAIT;
        end
      end
      WAIT: if (puf_valid) begin
        wr      = !mode_q;
        hd_n    = mode_q ? hd_total + 12'($countones(puf_response ^ ref_resp)) : hd_total;
        en_n    = 1'b0;
        timer_n = '0;
        state_n = GAP;
      end else if (timer == TW'(TIMEOUT - 1)) begin
        to_n    = 1'b1;
        en_n    = 1'b0;
        state_n = FINISH;
      end else timer_n = timer + 1'b1;
      GAP: if (idx == IW'(N_CHAL - 1)) state_n = FINISH;
      else begin
        idx_n   = idx + 1'b1;
        chal_n  = challenge + CHAL_STEP;
        en_n    = 1'b1;
        state_n = WAIT;
      end
      FINISH: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        enr_n   = enrolled | (!mode_q && !timeout_err);
        pass_n  = mode_q && enrolled && !timeout_err && ({20'd0, hd_total} <= 32'(THRESH));
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      timer       <= '0;
      mode_q      <= 1'b0;
      challenge   <= '0;
      puf_enable  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      enrolled    <= 1'b0;
      timeout_err <= 1'b0;
      hd_total    <= '0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      timer       <= timer_n;
      mode_q      <= mode_n;
      challenge   <= chal_n;
      puf_enable  <= en_n;
      busy        <= busy_n;
      done        <= done_n;
      pass        <= pass_n;
      enrolled    <= enr_n;
      timeout_err <= to_n;
      hd_total    <= hd_n;
    end
  end
  // enrollment response table, left unreset since enrolled gates its use
  always_ff @(posedge clk) begin
    if (wr) tbl[idx] <= puf_response;
  end
endmodule

// File: tb/tb_puf_auth_sequencer.sv
// tb_puf_auth_sequencer: randomized directed runs against a table-based model of the sequencer
module tb_puf_auth_sequencer;
  localparam int         N    = 16;
  localparam int         TH   = 16;
  localparam int         TO   = 100;
  localparam logic [7:0] BASE = 8'h00;
  localparam logic [7:0] STEP = 8'h01;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic        puf_valid = 1'b0;
  logic [7:0]  puf_response = 8'h00;
  logic [7:0]  challenge;
  logic        puf_enable, busy, done, pass, enrolled, timeout_err;
  logic [11:0] hd_total;

  int   npass = 0;
  int   ntot = 0;
  int   nfail = 0;
  bit   m_enrolled = 1'b0;
  logic [7:0] m_table [N];

  always #5 clk = ~clk;

  puf_auth_sequencer #(
    .N_CHAL(N), .CHAL_BASE(BASE), .CHAL_STEP(STEP), .THRESH(TH), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .challenge(challenge), .puf_enable(puf_enable),
    .puf_response(puf_response), .puf_valid(puf_valid),
    .busy(busy), .done(done), .pass(pass), .enrolled(enrolled),
    .timeout_err(timeout_err), .hd_total(hd_total)
  );

  function automatic logic [7:0] puf_f(input logic [7:0] c);
    return c ^ 8'hA5;
  endfunction

  function automatic logic [7:0] chal_of(input int i);
    return BASE + 8'(i) * STEP;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // hold: pulse index whose valid is withheld (timeout), -2: pulse 5 answers on the expiry cycle
  // rst_at: pulse index during which reset is asserted
  task automatic run(input bit m, input logic [7:0] mask, input int hold, input int rst_at);
    int pulses, dly, cnt, lowrun, fall_c, done_c, done_cnt, after, n_exp, exp_hd;
    bit prev_en, to_exp, skip, aborted, exp_pass, exp_enr;
    logic [7:0] cur;
    skip   = m && !m_enrolled;
    to_exp = !skip && hold >= 0;
    n_exp  = skip ? 0 : (rst_at >= 0 ? rst_at + 1 : (to_exp ? hold + 1 : N));
    exp_hd = 0;
    if (m && !skip)
      for (int i = 0; i < (to_exp ? hold : N); i++)
        exp_hd += $countones(puf_f(chal_of(i)) ^ mask ^ m_table[i]);
    exp_pass = m && !skip && !to_exp && exp_hd <= TH;
    exp_enr  = m ? m_enrolled : !to_exp;
    pulses = 0; dly = 0; cnt = 0; lowrun = 0; fall_c = -1; done_c = -1;
    done_cnt = 0; after = -1; prev_en = 1'b0; aborted = 1'b0; cur = 8'h00;
    @(negedge clk);
    start = 1'b1; mode = m; puf_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (puf_enable && !prev_en) begin
        if (pulses == 0) chk("first_rise_cycle", c, 0);
        else chk("gap_len", lowrun, 1);
        cur = chal_of(pulses);
        chk("challenge", challenge, cur);
        dly = (pulses == hold || pulses == rst_at) ? -1 :
              (hold == -2 && pulses == 5) ? TO - 1 : int'($urandom_range(0, 6));
        cnt = 0;
        pulses++;
      end else if (puf_enable) chk("challenge_stable", challenge, cur);
      if (!puf_enable && prev_en) begin
        chk("pulse_len", cnt, dly < 0 ? TO : dly + 1);
        fall_c = c;
        lowrun = 0;
      end
      if (!puf_enable) lowrun++;
      if (done) begin
        done_cnt++;
        if (done_c < 0) begin
          done_c = c;
          after = c + 4;
        end
      end
      if (after >= 0 && c >= after) break;
      puf_response = 8'($urandom);
      puf_valid = 1'b0;
      if (puf_enable) begin
        if (cnt == dly) begin
          puf_valid = 1'b1;
          puf_response = puf_f(cur) ^ mask;
        end
        cnt++;
      end else puf_valid = ($urandom_range(0, 3) == 0);
      start = busy && ($urandom_range(0, 7) == 0);
      if (start) mode = 1'($urandom_range(0, 1));
      if (rst_at >= 0 && puf_enable && pulses == rst_at + 1 && cnt == 3) begin
        reset = 1'b1;
        start = 1'b0;
        puf_valid = 1'b0;
        aborted = 1'b1;
      end
      prev_en = puf_enable;
      @(negedge clk);
      if (aborted) break;
    end
    start = 1'b0;
    puf_valid = 1'b0;
    if (aborted) begin
      reset = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_enable", puf_enable, 0);
      chk("rst_enrolled", enrolled, 0);
      chk("rst_pass", pass, 0);
      chk("rst_pulses", pulses, n_exp);
      m_enrolled = 1'b0;
      repeat (6) begin
        if (done) done_cnt++;
        @(negedge clk);
      end
      chk("rst_no_done", done_cnt, 0);
    end else begin
      chk("done_count", done_cnt, 1);
      chk("done_latency", done_c, skip ? 1 : (to_exp ? fall_c + 1 : fall_c + 2));
      chk("pulses", pulses, n_exp);
      chk("timeout_err", timeout_err, to_exp);
      chk("hd_total", hd_total, exp_hd);
      chk("pass", pass, exp_pass);
      chk("enrolled", enrolled, exp_enr);
      chk("busy_end", busy, 0);
      if (!m) begin
        if (!to_exp) for (int i = 0; i < N; i++) m_table[i] = puf_f(chal_of(i)) ^ mask;
        m_enrolled = !to_exp;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_enable", puf_enable, 0);
    chk("reset_done", done, 0);
    chk("reset_pass", pass, 0);
    chk("reset_enrolled", enrolled, 0);
    chk("reset_timeout", timeout_err, 0);
    chk("reset_hd", hd_total, 0);
    chk("reset_challenge", challenge, 0);
    reset = 1'b0;
    run(1'b1, 8'h00, -1, -1);
    run(1'b0, 8'h00, -1, -1);
    run(1'b1, 8'h00, -1, -1);
    run(1'b1, 8'h01, -1, -1);
    run(1'b1, 8'h03, -1, -1);
    run(1'b1, 8'h00, -2, -1);
    repeat (4) run(1'b1, 8'($urandom_range(0, 255)), -1, -1);
    run(1'b1, 8'($urandom_range(1, 255)), 3, -1);
    run(1'b0, 8'h00, 3, -1);
    run(1'b1, 8'h00, -1, -1);
    run(1'b0, 8'($urandom_range(0, 255)), -1, -1);
    repeat (3) run(1'b1, 8'($urandom_range(0, 255)), -1, -1);
    run(1'b0, 8'h00, -1, 7);
    run(1'b0, 8'h00, -1, -1);
    run(1'b1, 8'h00, -1, -1);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
